// File: rtl/clk_div_gen.sv
// clk_div_gen: programmable clock divider gated by PLL lock qualification.
// Produces a registered divided clock (clock_out) and a period-start pulse
// (tick) once pll_locked has been stable for LOCK_CYCLES cycles. A new
// period/high-time pair is taken through a one-deep pending register and
// applied only at a period boundary, so output pulses are never truncated.
// Optional: define CLKDIV_PERIOD_COUNT_EN to add the 16-bit period_count output.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_QUAL | waiting for pll_locked to stay high LOCK_CYCLES cycles
// ST_RUN  | lock qualified, divider running (active=1)

module clk_div_gen #(
  parameter int WIDTH        = 8,
  parameter int DEFAULT_DIV  = 9,
  parameter int DEFAULT_HIGH = 4,
  parameter int LOCK_CYCLES  = 16
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             pll_locked,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  output logic             clock_out,
  output logic             tick,
  output logic             active
`ifdef CLKDIV_PERIOD_COUNT_EN
  ,
  output logic [15:0]      period_count
`endif
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0]    LOCK_MAX = LW'(LOCK_CYCLES);
  localparam logic [WIDTH-1:0] MIN_DIV  = WIDTH'(2);
  localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_HIGH = WIDTH'(DEFAULT_HIGH);

  typedef enum logic {ST_QUAL = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [LW-1:0]    lock_cnt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] div_act, high_act, div_nxt, high_nxt;
  logic [WIDTH-1:0] pend_div, pend_high;
  logic [WIDTH-1:0] cfg_div_c, cfg_high_c;
  logic             pend_vld;
  logic             run_nxt, wrap, apply;

  assign active = (state == ST_RUN);

  // Lock qualification counter: any low cycle restarts qualification.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      lock_cnt <= '0;
    end else if (!pll_locked) begin
      lock_cnt <= '0;
    end else if (lock_cnt != LOCK_MAX) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) state <= ST_QUAL;
    else       state <= state_nxt;
  end

  // Next state, counter update and config-apply decision.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_QUAL: if (pll_locked && lock_cnt == LOCK_MAX) state_nxt = ST_RUN;
      ST_RUN:  if (!pll_locked) state_nxt = ST_QUAL;
      default: state_nxt = ST_QUAL;
    endcase
    run_nxt  = (state_nxt == ST_RUN);
    wrap     = active && (cnt == div_act - 1'b1);
    apply    = pend_vld && (!active || wrap);
    div_nxt  = apply ? pend_div  : div_act;
    high_nxt = apply ? pend_high : high_act;
    if (!run_nxt || !active || wrap) cnt_nxt = '0;
    else                             cnt_nxt = cnt + 1'b1;
  end

  // Clamp an offered config so the period is at least 2 and high < period.
  always_comb begin
    cfg_div_c  = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
    cfg_high_c = (cfg_high >= cfg_div_c) ? (cfg_div_c - 1'b1) : cfg_high;
  end

  // Divider counter and registered outputs, computed from next-cycle values.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      clock_out <= 1'b0;
      tick      <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      clock_out <= run_nxt && (cnt_nxt >= div_nxt - high_nxt);
      tick      <= run_nxt && (cnt_nxt == '0);
    end
  end

  // Config handshake: capture into pending, apply only at a period boundary.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      div_act   <= DEF_DIV;
      high_act  <= DEF_HIGH;
      pend_div  <= '0;
      pend_high <= '0;
      pend_vld  <= 1'b0;
      cfg_ready <= 1'b1;
    end else if (apply) begin
      div_act   <= pend_div;
      high_act  <= pend_high;
      pend_vld  <= 1'b0;
      cfg_ready <= 1'b1;
    end else if (cfg_valid && cfg_ready) begin
      pend_div  <= cfg_div_c;
      pend_high <= cfg_high_c;
      pend_vld  <= 1'b1;
      cfg_ready <= 1'b0;
    end
  end

`ifdef CLKDIV_PERIOD_COUNT_EN
  // Completed-period counter, saturating, cleared whenever the divider stops.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      period_count <= '0;
    end else if (!run_nxt) begin
      period_count <= '0;
    end else if (wrap && period_count != 16'hFFFF) begin
      period_count <= period_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: scoreboard bench for clk_div_gen. Each scenario pushes the
// expected (active, clock_out, tick, cfg_ready) for the coming edge, then the
// edge is taken and the entry is popped and compared against the outputs.
// Expected values come from the period/phase formula of each scenario.

module tb_clk_div_gen;

  localparam int WIDTH = 8;

  logic             clock_in = 1'b0;
  logic             reset;
  logic             pll_locked;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_div;
  logic [WIDTH-1:0] cfg_high;
  logic             clock_out;
  logic             tick;
  logic             active;
`ifdef CLKDIV_PERIOD_COUNT_EN
  logic [15:0]      period_count;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct packed {
    logic act;
    logic co;
    logic tk;
    logic rdy;
  } exp_t;

  exp_t sb[$];

  clk_div_gen #(
    .WIDTH(WIDTH), .DEFAULT_DIV(9), .DEFAULT_HIGH(4), .LOCK_CYCLES(16)
  ) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .pll_locked(pll_locked),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .clock_out (clock_out),
    .tick      (tick),
    .active    (active)
`ifdef CLKDIV_PERIOD_COUNT_EN
    ,
    .period_count(period_count)
`endif
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input logic act, input logic co, input logic tk, input logic rdy);
    exp_t e;
    e.act = act; e.co = co; e.tk = tk; e.rdy = rdy;
    sb.push_back(e);
  endtask

  // Take one edge and compare the outputs against the oldest expectation.
  task automatic step();
    exp_t e;
    @(posedge clock_in);
    #1;
    cyc++;
    if (sb.size() == 0) begin
      chk($sformatf("c%0d_sb_depth", cyc), sb.size(), 1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("c%0d_active", cyc), active, e.act);
      chk($sformatf("c%0d_clock_out", cyc), clock_out, e.co);
      chk($sformatf("c%0d_tick", cyc), tick, e.tk);
      chk($sformatf("c%0d_cfg_ready", cyc), cfg_ready, e.rdy);
    end
  endtask

  // n edges with the divider stopped.
  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      push_exp(1'b0, 1'b0, 1'b0, rdy);
      step();
    end
  endtask

  // n running edges of period d, high h, starting at phase p0.
  task automatic run(input int n, input int d, input int h, input int p0, input logic rdy);
    int p;
    for (int i = 0; i < n; i++) begin
      p = (p0 + i) % d;
      push_exp(1'b1, p >= d - h, p == 0, rdy);
      step();
    end
  endtask

  task automatic offer(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] h);
    cfg_valid = 1'b1;
    cfg_div   = d;
    cfg_high  = h;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_active"}, active, 0);
    chk({tag, "_clock_out"}, clock_out, 0);
    chk({tag, "_tick"}, tick, 0);
    chk({tag, "_cfg_ready"}, cfg_ready, 1);
  endtask

  initial begin
    reset      = 1'b1;
    pll_locked = 1'b1;
    cfg_valid  = 1'b0;
    cfg_div    = '0;
    cfg_high   = '0;
    repeat (2) @(posedge clock_in);
    #1;
    check_reset_outputs("rst0");

    // Defaults with lock held from release: active at edge 17, 000001111.
    reset = 1'b0;
    idle(16, 1'b1);
    run(27, 9, 4, 0, 1'b1);

    // Mid-period config 4/2: ready low until wrap, then 0011 from counter 0.
    run(3, 9, 4, 0, 1'b1);
`ifdef CLKDIV_PERIOD_COUNT_EN
    chk("period_count_3", period_count, 3);
`endif
    offer(8'd4, 8'd2);
    run(1, 9, 4, 3, 1'b0);
    cfg_valid = 1'b0;
    run(5, 9, 4, 4, 1'b0);
    run(12, 4, 2, 0, 1'b1);

    // Offer 1/5 on a wrap edge: captured now, applied next wrap as 2/1.
    offer(8'd1, 8'd5);
    run(1, 4, 2, 0, 1'b0);
    cfg_valid = 1'b0;
    run(3, 4, 2, 1, 1'b0);
    run(8, 2, 1, 0, 1'b1);

    // Back to 9/4, then drop lock for one cycle at counter 6.
    offer(8'd9, 8'd4);
    run(1, 2, 1, 0, 1'b0);
    cfg_valid = 1'b0;
    run(1, 2, 1, 1, 1'b0);
    run(7, 9, 4, 0, 1'b1);
    pll_locked = 1'b0;
    idle(1, 1'b1);
    pll_locked = 1'b1;
`ifdef CLKDIV_PERIOD_COUNT_EN
    chk("period_count_lost", period_count, 0);
`endif
    idle(16, 1'b1);
    run(18, 9, 4, 0, 1'b1);

    // Reset mid-period with a config pending: defaults must come back.
    run(4, 9, 4, 0, 1'b1);
    offer(8'd4, 8'd1);
    run(1, 9, 4, 4, 1'b0);
    cfg_valid = 1'b0;
    run(1, 9, 4, 5, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
`ifdef CLKDIV_PERIOD_COUNT_EN
    chk("period_count_rst", period_count, 0);
`endif
    repeat (2) @(posedge clock_in);
    #1;
    reset = 1'b0;
    idle(16, 1'b1);
    run(27, 9, 4, 0, 1'b1);

    // High time 0: clock_out constant low while tick keeps running.
    offer(8'd3, 8'd0);
    run(1, 9, 4, 0, 1'b0);
    cfg_valid = 1'b0;
    run(8, 9, 4, 1, 1'b0);
    run(9, 3, 0, 0, 1'b1);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
